filt_xfer: RTL and testbench

Parametrised memory-to-memory FIR transfer engine. On `start` it reads `len` signed samples from a source RAM region, filters them through a TAPS-tap FIR with run-time loadable coefficients, and writes scaled results to a destination RAM region, pulsing `done` on completion. It sits between two synchronous single-port RAMs (1-cycle read latency) and is controlled by a host/sequencer through a start/busy/done handshake.

---
 rtl/filt_xfer_pkg.sv | 38 +++
 rtl/filt_xfer_mac.sv | 69 ++++++
 rtl/filt_xfer.sv | 136 +++++++++++++
 tb/tb_filt_xfer.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/filt_xfer_pkg.sv
// filt_xfer shared types and helpers: FSM state enum, accumulator
// width function, output reduction (saturate if FILT_XFER_SAT_EN, else wrap).
package filt_xfer_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  function automatic int fx_acc_w(
    input int dw,
    input int cw,
    input int taps
  );
    return dw + cw + $clog2(taps);
  endfunction

  // Reduce a sign-extended value to dw bits, returned sign-extended.
  function automatic logic signed [63:0] fx_reduce(
    input logic signed [63:0] v,
    input int                 dw
  );
`ifdef FILT_XFER_SAT_EN
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (dw - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
`else
    return (v <<< (64 - dw)) >>> (64 - dw);
`endif
  endfunction

endpackage

// File: rtl/filt_xfer_mac.sv
// filt_xfer FIR datapath: tap delay line (clear/shift), coefficient
// registers, signed multiply-add tree and registered accumulator acc_o.
module filt_xfer_mac
  import filt_xfer_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int COEF_W = 8,
  parameter int TAPS   = 14,
  parameter int IW     = $clog2(TAPS),
  parameter int AW     = fx_acc_w(DATA_W, COEF_W, TAPS)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clr_i,
  input  logic                     shift_i,
  input  logic signed [DATA_W-1:0] din_i,
  input  logic                     acc_en_i,
  input  logic                     cwe_i,
  input  logic [IW-1:0]            cidx_i,
  input  logic signed [COEF_W-1:0] cdata_i,
  output logic signed [AW-1:0]     acc_o
);

  localparam int PW = DATA_W + COEF_W;

  logic signed [DATA_W-1:0] tap_q  [TAPS];
  logic signed [COEF_W-1:0] coef_q [TAPS];
  logic signed [AW-1:0]     acc_q;
  logic signed [AW-1:0]     sum;
  logic signed [PW-1:0]     prod;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < TAPS; k++) tap_q[k] <= '0;
    end else if (clr_i) begin
      for (int k = 0; k < TAPS; k++) tap_q[k] <= '0;
    end else if (shift_i) begin
      tap_q[0] <= din_i;
      for (int k = 1; k < TAPS; k++) tap_q[k] <= tap_q[k-1];
    end
  end

  // Indices with no matching tap simply write nothing.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < TAPS; k++) coef_q[k] <= '0;
    end else if (cwe_i) begin
      for (int k = 0; k < TAPS; k++)
        if (cidx_i == IW'(k)) coef_q[k] <= cdata_i;
    end
  end

  always_comb begin
    sum  = '0;
    prod = '0;
    for (int k = 0; k < TAPS; k++) begin
      prod = PW'(tap_q[k]) * PW'(coef_q[k]);
      sum  = sum + AW'(prod);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)         acc_q <= '0;
    else if (acc_en_i) acc_q <= sum;
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/filt_xfer.sv
// filt_xfer top: FSM, address counters, write-side valid pipeline.
// Ports: start/len/bases in, coef_* load, rd_*/wr_* RAM side, busy/done; FILT_XFER_SAT_EN.
module filt_xfer
  import filt_xfer_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int COEF_W  = 8,
  parameter int TAPS    = 14,
  parameter int ADDR_W  = 10,
  parameter int FRAC_SH = 7
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [ADDR_W:0]          len,
  input  logic [ADDR_W-1:0]        src_base,
  input  logic [ADDR_W-1:0]        dst_base,
  input  logic                     coef_we,
  input  logic [$clog2(TAPS)-1:0]  coef_idx,
  input  logic [COEF_W-1:0]        coef_data,
  output logic [ADDR_W-1:0]        rd_addr,
  input  logic [DATA_W-1:0]        rd_data,
  output logic [ADDR_W-1:0]        wr_addr,
  output logic [DATA_W-1:0]        wr_data,
  output logic                     wr_en,
  output logic                     busy,
  output logic                     done
);

  localparam int IW = $clog2(TAPS);
  localparam int AW = fx_acc_w(DATA_W, COEF_W, TAPS);
  localparam logic [ADDR_W:0] ONE = 1;

  state_e              st_q, st_d;
  logic [ADDR_W:0]     rem_q, rem_d;
  logic [1:0]          dcnt_q, dcnt_d;
  logic [ADDR_W-1:0]   ra_q, ra_d;
  logic [ADDR_W-1:0]   wa_q, wa_d;
  logic                v1_q, v2_q, v3_q;
  logic                clr;
  logic                cwe;
  logic signed [AW-1:0] acc;
  logic signed [AW-1:0] acc_sh;
  logic signed [63:0]   acc64;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st_q   <= S_IDLE;
      rem_q  <= '0;
      dcnt_q <= '0;
      ra_q   <= '0;
      wa_q   <= '0;
      v1_q   <= 1'b0;
      v2_q   <= 1'b0;
      v3_q   <= 1'b0;
    end else begin
      st_q   <= st_d;
      rem_q  <= rem_d;
      dcnt_q <= dcnt_d;
      ra_q   <= ra_d;
      wa_q   <= wa_d;
      v1_q   <= (st_q == S_RUN);
      v2_q   <= v1_q;
      v3_q   <= v2_q;
    end
  end

  always_comb begin
    st_d   = st_q;
    rem_d  = rem_q;
    dcnt_d = dcnt_q;
    ra_d   = ra_q;
    wa_d   = wa_q;
    clr    = 1'b0;
    if (v3_q) wa_d = wa_q + ADDR_W'(1);
    unique case (st_q)
      S_IDLE: begin
        if (start) begin
          if (len != '0) begin
            st_d  = S_RUN;
            rem_d = len;
            ra_d  = src_base;
            wa_d  = dst_base;
            clr   = 1'b1;
          end else begin
            st_d = S_DONE;
          end
        end
      end
      S_RUN: begin
        ra_d   = ra_q + ADDR_W'(1);
        rem_d  = rem_q - ONE;
        dcnt_d = 2'd0;
        if (rem_q == ONE) st_d = S_DRAIN;
      end
      S_DRAIN: begin
        dcnt_d = dcnt_q + 2'd1;
        if (dcnt_q == 2'd2) st_d = S_DONE;
      end
      S_DONE:  st_d = S_IDLE;
      default: st_d = S_IDLE;
    endcase
  end

  assign cwe = coef_we & ((st_q == S_IDLE) | (st_q == S_DONE));

  filt_xfer_mac #(
    .DATA_W (DATA_W),
    .COEF_W (COEF_W),
    .TAPS   (TAPS),
    .IW     (IW),
    .AW     (AW)
  ) u_mac (
    .clk      (clk),
    .reset    (reset),
    .clr_i    (clr),
    .shift_i  (v1_q),
    .din_i    (rd_data),
    .acc_en_i (v2_q),
    .cwe_i    (cwe),
    .cidx_i   (coef_idx),
    .cdata_i  (coef_data),
    .acc_o    (acc)
  );

  assign acc_sh  = acc >>> FRAC_SH;
  assign acc64   = {{(64-AW){acc_sh[AW-1]}}, acc_sh};
  assign wr_data = DATA_W'(fx_reduce(acc64, DATA_W));

  assign rd_addr = ra_q;
  assign wr_addr = wa_q;
  assign wr_en   = v3_q;
  assign busy    = (st_q == S_RUN) | (st_q == S_DRAIN);
  assign done    = (st_q == S_DONE);

endmodule

// File: tb/tb_filt_xfer.sv
// Self-checking bench for filt_xfer: RAM model, FIR reference model,
// directed and randomized transfers checked cycle by cycle.
module tb_filt_xfer;

  localparam int DW  = 8;
  localparam int CW  = 8;
  localparam int TP  = 14;
  localparam int AWD = 10;
  localparam int FSH = 2;

  logic           clk;
  logic           reset;
  logic           start;
  logic [AWD:0]   len;
  logic [AWD-1:0] src_base;
  logic [AWD-1:0] dst_base;
  logic           coef_we;
  logic [3:0]     coef_idx;
  logic [CW-1:0]  coef_data;
  logic [AWD-1:0] rd_addr;
  logic [DW-1:0]  rd_data;
  logic [AWD-1:0] wr_addr;
  logic [DW-1:0]  wr_data;
  logic           wr_en;
  logic           busy;
  logic           done;

  filt_xfer #(
    .DATA_W (DW),
    .COEF_W (CW),
    .TAPS   (TP),
    .ADDR_W (AWD),
    .FRAC_SH(FSH)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .len      (len),
    .src_base (src_base),
    .dst_base (dst_base),
    .coef_we  (coef_we),
    .coef_idx (coef_idx),
    .coef_data(coef_data),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .wr_en    (wr_en),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [DW-1:0] src_mem [1024];
  always @(posedge clk) rd_data <= src_mem[rd_addr];

  int         h [TP];
  int         n_chk;
  int         n_fail;
  logic [7:0] got_q [$];
  logic [7:0] base_q [$];

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // y[n] = sum h[k]*x[n-k], x before the transfer start is zero.
  function automatic logic [7:0] ref_y(input int n, input int src);
    longint acc;
    longint sh;
    acc = 0;
    for (int k = 0; k < TP; k++)
      if (n - k >= 0)
        acc += longint'(h[k]) *
               longint'($signed(src_mem[(src + n - k) % 1024]));
    sh = acc >>> FSH;
`ifdef FILT_XFER_SAT_EN
    if (sh > 127)  sh = 127;
    if (sh < -128) sh = -128;
`endif
    return sh[7:0];
  endfunction

  task automatic load_coef(input int idx, input int val);
    @(negedge clk);
    coef_we   = 1'b1;
    coef_idx  = 4'(idx);
    coef_data = 8'(val);
    @(negedge clk);
    coef_we = 1'b0;
    if (idx < TP) h[idx] = val;
  endtask

  task automatic load_all(input int mode);
    for (int k = 0; k < TP; k++) begin
      if (mode == 0) load_coef(k, 0);
      else           load_coef(k, $signed(8'($urandom)));
    end
  endtask

  task automatic fill_rand();
    for (int i = 0; i < 1024; i++) src_mem[i] = 8'($urandom);
  endtask

  // Start at edge 0, then check every cycle up to one past done.
  task automatic run_xfer(input int n, input int src, input int dst);
    int             dc;
    logic [AWD-1:0] ra0;
    logic           wexp;
    dc = (n == 0) ? 1 : n + 4;
    @(negedge clk);
    ra0      = rd_addr;
    start    = 1'b1;
    len      = 11'(n);
    src_base = 10'(src);
    dst_base = 10'(dst);
    @(posedge clk);
    got_q.delete();
    for (int c = 1; c <= dc + 1; c++) begin
      @(negedge clk);
      start = 1'b0;
      wexp  = (n > 0) && (c >= 4) && (c <= n + 3);
      chk("wr_en", 32'(wr_en), 32'(wexp));
      if (wexp && wr_en) begin
        chk("wr_addr", 32'(wr_addr), 32'((dst + c - 4) % 1024));
        chk("wr_data", 32'(wr_data), 32'(ref_y(c - 4, src)));
        got_q.push_back(wr_data);
      end
      if (n > 0 && c <= n)
        chk("rd_addr", 32'(rd_addr), 32'((src + c - 1) % 1024));
      if (n == 0) chk("rd_hold", 32'(rd_addr), 32'(ra0));
      chk("done", 32'(done), 32'(c == dc));
      chk("busy", 32'(busy), 32'((n > 0) && (c < dc)));
    end
  endtask

  task automatic chk_idle_outs(input string tag);
    chk({tag, "_rd_addr"}, 32'(rd_addr), 0);
    chk({tag, "_wr_addr"}, 32'(wr_addr), 0);
    chk({tag, "_wr_data"}, 32'(wr_data), 0);
    chk({tag, "_wr_en"},   32'(wr_en),   0);
    chk({tag, "_busy"},    32'(busy),    0);
    chk({tag, "_done"},    32'(done),    0);
  endtask

  int imp_exp [6];
  logic [7:0] sat_exp;

  initial begin
    n_chk     = 0;
    n_fail    = 0;
    reset     = 1'b1;
    start     = 1'b0;
    len       = '0;
    src_base  = '0;
    dst_base  = '0;
    coef_we   = 1'b0;
    coef_idx  = '0;
    coef_data = '0;
    for (int k = 0; k < TP; k++) h[k] = 0;
    for (int i = 0; i < 1024; i++) src_mem[i] = '0;
    #12;
    chk_idle_outs("rst");
    @(negedge clk);
    reset = 1'b0;

    // Impulse: x=4 with FRAC_SH=2 gives h back directly.
    load_coef(0, 1);
    load_coef(1, 2);
    load_coef(2, 3);
    src_mem[100] = 8'd4;
    imp_exp = '{1, 2, 3, 0, 0, 0};
    run_xfer(6, 100, 200);
    chk("imp_n", 32'(got_q.size()), 6);
    for (int i = 0; i < 6; i++)
      if (i < got_q.size()) chk("imp_y", 32'(got_q[i]), 32'(imp_exp[i]));

    // Out-of-range coefficient index must not disturb anything.
    load_coef(15, 99);
    load_coef(14, -7);
    run_xfer(6, 100, 200);

    // Zero-length transfer.
    run_xfer(0, 5, 6);

    // Address wrap on both sides.
    fill_rand();
    load_all(1);
    run_xfer(4, 1022, 1021);

    // Saturation vs wrap: 127*127 >>> 2 = 4032.
    load_all(0);
    load_coef(0, 127);
    for (int i = 300; i < 303; i++) src_mem[i] = 8'd127;
`ifdef FILT_XFER_SAT_EN
    sat_exp = 8'd127;
`else
    sat_exp = 8'hC0;
`endif
    run_xfer(3, 300, 400);
    if (got_q.size() > 0) chk("sat_y", 32'(got_q[0]), 32'(sat_exp));
    else                  chk("sat_n", 32'(got_q.size()), 3);

    // Randomized transfers.
    for (int it = 0; it < 6; it++) begin
      fill_rand();
      load_all(1);
      run_xfer(int'($urandom_range(1, 40)), int'($urandom_range(0, 1023)),
               int'($urandom_range(0, 1023)));
    end

    // Coefficient write while busy is ignored.
    fill_rand();
    load_all(1);
    run_xfer(16, 50, 600);
    base_q = got_q;
    fork
      run_xfer(16, 50, 600);
      begin
        repeat (4) @(negedge clk);
        coef_we   = 1'b1;
        coef_idx  = 4'd0;
        coef_data = 8'(h[0] + 37);
        @(negedge clk);
        coef_we = 1'b0;
      end
    join
    chk("cwb_n", 32'(got_q.size()), 32'(base_q.size()));
    for (int i = 0; i < 16; i++)
      if (i < got_q.size() && i < base_q.size())
        chk("cwb_y", 32'(got_q[i]), 32'(base_q[i]));

    // Full-memory length.
    fill_rand();
    load_all(1);
    run_xfer(1024, 17, 900);

    // Reset in cycle 5 of a 20-sample transfer.
    fill_rand();
    load_all(1);
    @(negedge clk);
    start    = 1'b1;
    len      = 11'd20;
    src_base = 10'd0;
    dst_base = 10'd0;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2 reset = 1'b1;
    #1 chk_idle_outs("abort");
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < TP; k++) h[k] = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      chk("post_wr_en", 32'(wr_en), 0);
      chk("post_done",  32'(done),  0);
    end
    run_xfer(3, 10, 20);
    load_all(1);
    run_xfer(3, 10, 20);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
